// File: rtl/insn_seq_ctrl.sv
// insn_seq_ctrl: multi-cycle RV32I instruction sequencer.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB, performs the
// imem/dmem handshakes, and owns the PC and the retired-instruction counter.
// Illegal opcodes, SYSTEM instructions and misaligned redirect targets park
// the core in TRAP until reset.
//
// Handshake rule: a request (imem_req_o / dmem_req_o) is held high for as
// long as the FSM sits in its waiting state; the transfer completes on the
// first rising edge where the matching ack is high (ack may coincide with
// the first request cycle). Acks seen in any other state are ignored.
module insn_seq_ctrl #(
   parameter int                 DWIDTH   = 32,
   parameter int                 AWIDTH   = 32,
   parameter logic [AWIDTH-1:0]  BASEADDR = AWIDTH'(32'h0100_0000)
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_o,
   output logic [AWIDTH-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [DWIDTH-1:0] imem_rdata_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   input  logic              dmem_ack_i,
   input  logic              br_taken_i,
   input  logic [AWIDTH-1:0] target_i,
   output logic [AWIDTH-1:0] pc_o,
   output logic [DWIDTH-1:0] insn_o,
   output logic [6:0]        opcode_o,
   output logic [2:0]        state_o,
   output logic              exec_en_o,
   output logic              rf_we_o,
   output logic              trap_o,
   output logic [1:0]        trap_cause_o,
   output logic [31:0]       instret_o
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_MISALGN = 2'd2;
   localparam logic [1:0] CAUSE_SYSTEM  = 2'd3;

   state_t            state;
   logic              redir_q;
   logic [AWIDTH-1:0] tgt_q;

   logic is_legal;
   logic is_system;
   logic is_jump;
   logic is_branch;
   logic is_mem;
   logic is_store;
   logic writes_rd;
   logic redir_now;

   assign opcode_o    = insn_o[6:0];
   assign imem_addr_o = pc_o;
   assign state_o     = state;
   assign trap_o      = (state == S_TRAP);

   // Opcode classification of the latched instruction.
   always_comb begin
      is_legal  = 1'b0;
      is_system = 1'b0;
      is_jump   = 1'b0;
      is_branch = 1'b0;
      is_mem    = 1'b0;
      is_store  = 1'b0;
      writes_rd = 1'b0;
      case (opcode_o)
         OP_LUI, OP_AUIPC, OP_IMM, OP_OP: begin
            is_legal  = 1'b1;
            writes_rd = 1'b1;
         end
         OP_JAL, OP_JALR: begin
            is_legal  = 1'b1;
            is_jump   = 1'b1;
            writes_rd = 1'b1;
         end
         OP_BRANCH: begin
            is_legal  = 1'b1;
            is_branch = 1'b1;
         end
         OP_LOAD: begin
            is_legal  = 1'b1;
            is_mem    = 1'b1;
            writes_rd = 1'b1;
         end
         OP_STORE: begin
            is_legal  = 1'b1;
            is_mem    = 1'b1;
            is_store  = 1'b1;
         end
         OP_FENCE:  is_legal  = 1'b1;
         OP_SYSTEM: is_system = 1'b1;
         default: ;
      endcase
   end

   assign redir_now = is_jump | (is_branch & br_taken_i);

   // Strobes come from the registered state only; reset masks them so nothing
   // fires while the core is being reinitialised.
   always_comb begin
      imem_req_o = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      exec_en_o  = 1'b0;
      rf_we_o    = 1'b0;
      if (!reset) begin
         imem_req_o = (state == S_FETCH);
         dmem_req_o = (state == S_MEM);
         dmem_we_o  = (state == S_MEM) & is_store;
         exec_en_o  = (state == S_EXECUTE);
         rf_we_o    = (state == S_WB) & writes_rd & (insn_o[11:7] != 5'd0);
      end
   end

   // Sequencer FSM with its architectural registers (PC, instruction, counter).
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_FETCH;
         pc_o         <= BASEADDR;
         insn_o       <= '0;
         instret_o    <= '0;
         trap_cause_o <= CAUSE_NONE;
         redir_q      <= 1'b0;
         tgt_q        <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_ack_i) begin
                  insn_o <= imem_rdata_i;
                  state  <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (is_legal) begin
                  state <= S_EXECUTE;
               end else begin
                  state        <= S_TRAP;
                  trap_cause_o <= is_system ? CAUSE_SYSTEM : CAUSE_ILLEGAL;
               end
            end
            S_EXECUTE: begin
               redir_q <= redir_now;
               tgt_q   <= target_i;
               if (redir_now && (target_i[1:0] != 2'b00)) begin
                  state        <= S_TRAP;
                  trap_cause_o <= CAUSE_MISALGN;
               end else if (is_mem) begin
                  state <= S_MEM;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_ack_i) begin
                  state <= S_WB;
               end
            end
            S_WB: begin
               pc_o      <= redir_q ? tgt_q : (pc_o + AWIDTH'(4));
               instret_o <= instret_o + 32'd1;
               state     <= S_FETCH;
            end
            S_TRAP: state <= S_TRAP;
            default: begin
               state        <= S_TRAP;
               trap_cause_o <= CAUSE_ILLEGAL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_insn_seq_ctrl.sv
// tb_insn_seq_ctrl: directed table, hand-written reset/wrap sequences and a
// randomized instruction stream checked against an instruction-level model.
module tb_insn_seq_ctrl;

   localparam logic [31:0] BASE = 32'h0100_0000;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic        dmem_ack_i = 1'b0;
   logic        br_taken_i = 1'b0;
   logic [31:0] target_i = '0;
   logic [31:0] pc_o;
   logic [31:0] insn_o;
   logic [6:0]  opcode_o;
   logic [2:0]  state_o;
   logic        exec_en_o;
   logic        rf_we_o;
   logic        trap_o;
   logic [1:0]  trap_cause_o;
   logic [31:0] instret_o;

   always #5 clk = ~clk;

   insn_seq_ctrl dut (
      .clk(clk), .reset(reset),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
      .br_taken_i(br_taken_i), .target_i(target_i),
      .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .state_o(state_o),
      .exec_en_o(exec_en_o), .rf_we_o(rf_we_o), .trap_o(trap_o),
      .trap_cause_o(trap_cause_o), .instret_o(instret_o)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] m_pc;
   logic [31:0] m_instret;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; leaves the bench just after a rising edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      imem_ack_i = 1'b0;
      dmem_ack_i = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_pc = BASE;
      m_instret = '0;
   endtask

   // Runs one instruction from its first FETCH cycle to its end (WB done or
   // TRAP entered). Expected per-cycle states come from the instruction-level
   // rules: FETCH for 1+iw cycles, DECODE, EXECUTE, MEM for 1+dw cycles, WB.
   task automatic do_insn(input logic [31:0] insn, input logic brt, input logic [31:0] tgt,
                          input int iw, input int dw, input bit spur,
                          output int lat_n, output int rfwe_n, output int dreq_n,
                          output int dwe_n, output bit trapped);
      logic [6:0]  op;
      bit          legal, sys, jump, branch, mem, store, wr, redir;
      logic [1:0]  cause;
      logic [2:0]  exp_q[$];
      logic [2:0]  es;
      int          fw, mw;
      op     = insn[6:0];
      legal  = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
      sys    = (op == 7'h73);
      jump   = op inside {7'h6F, 7'h67};
      branch = (op == 7'h63);
      mem    = op inside {7'h03, 7'h23};
      store  = (op == 7'h23);
      wr     = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) && (insn[11:7] != 5'd0);
      redir  = jump || (branch && brt);
      trapped = 1'b0;
      cause   = 2'd0;
      for (int i = 0; i <= iw; i++) exp_q.push_back(3'd0);
      exp_q.push_back(3'd1);
      if (!legal) begin
         trapped = 1'b1;
         cause   = sys ? 2'd3 : 2'd1;
      end else begin
         exp_q.push_back(3'd2);
         if (redir && (tgt[1:0] != 2'b00)) begin
            trapped = 1'b1;
            cause   = 2'd2;
         end else begin
            if (mem) for (int i = 0; i <= dw; i++) exp_q.push_back(3'd3);
            exp_q.push_back(3'd4);
         end
      end
      lat_n = 0; rfwe_n = 0; dreq_n = 0; dwe_n = 0;
      fw = 0; mw = 0;
      br_taken_i = brt;
      target_i   = tgt;
      while (exp_q.size() > 0) begin
         es = exp_q.pop_front();
         @(negedge clk);
         check("state", state_o, es);
         check("imem_req", imem_req_o, es == 3'd0);
         check("imem_addr", imem_addr_o, m_pc);
         check("exec_en", exec_en_o, es == 3'd2);
         check("dmem_req", dmem_req_o, es == 3'd3);
         check("dmem_we", dmem_we_o, (es == 3'd3) && store);
         check("rf_we", rf_we_o, (es == 3'd4) && wr);
         if (state_o < 3'd5) lat_n++;
         rfwe_n += rf_we_o;
         dreq_n += dmem_req_o;
         dwe_n  += dmem_we_o;
         imem_ack_i   = 1'b0;
         dmem_ack_i   = 1'b0;
         imem_rdata_i = $urandom;
         if (imem_req_o) begin
            if (fw == iw) begin
               imem_ack_i   = 1'b1;
               imem_rdata_i = insn;
            end
            fw++;
         end else if (spur) begin
            imem_ack_i = ($urandom_range(0, 2) == 0);
         end
         if (dmem_req_o) begin
            dmem_ack_i = (mw == dw);
            mw++;
         end else if (spur) begin
            dmem_ack_i = ($urandom_range(0, 2) == 0);
         end
      end
      @(posedge clk);
      #1;
      imem_ack_i = 1'b0;
      dmem_ack_i = 1'b0;
      if (!trapped) begin
         m_pc = redir ? tgt : (m_pc + 32'd4);
         m_instret = m_instret + 32'd1;
      end
      check("end_state", state_o, trapped ? 3'd5 : 3'd0);
      check("trap", trap_o, trapped);
      check("trap_cause", trap_cause_o, cause);
      check("pc", pc_o, m_pc);
      check("instret", instret_o, m_instret);
      check("insn", insn_o, insn);
      check("opcode", opcode_o, insn[6:0]);
   endtask

   // Core must stay parked: no strobes, PC and counter frozen, acks ignored.
   task automatic check_parked(input logic [1:0] cause);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("park_imem_req", imem_req_o, 1'b0);
         check("park_dmem_req", dmem_req_o, 1'b0);
         check("park_exec_en", exec_en_o | rf_we_o, 1'b0);
         check("park_trap", trap_o, 1'b1);
         check("park_cause", trap_cause_o, cause);
         check("park_pc", pc_o, m_pc);
         check("park_instret", instret_o, m_instret);
         imem_ack_i = 1'b1;
         dmem_ack_i = 1'b1;
      end
      @(posedge clk);
      #1;
      imem_ack_i = 1'b0;
      dmem_ack_i = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [31:0] insn;
      logic        brt;
      logic [31:0] tgt;
      int          iw;
      int          dw;
      int          exp_lat;
      int          exp_rfwe;
      int          exp_dreq;
      int          exp_dwe;
      logic [31:0] exp_pc;
      logic [31:0] exp_instret;
      logic        exp_trap;
      logic [1:0]  exp_cause;
   } vec_t;

   vec_t vecs[14];

   initial begin
      int lat_n, rfwe_n, dreq_n, dwe_n;
      bit trapped;
      logic [31:0] ops[10];

      //          insn          brt   tgt           iw dw lat rf dr dw  pc            ir  trap cause
      vecs[0]  = '{32'h00500093, 1'b0, 32'h0,        0, 0, 4, 1, 0, 0, 32'h0100_0004, 1, 1'b0, 2'd0}; // addi x1
      vecs[1]  = '{32'h0010A023, 1'b0, 32'h0,        0, 3, 8, 0, 4, 4, 32'h0100_0004, 1, 1'b0, 2'd0}; // sw, 3 waits
      vecs[2]  = '{32'h0000A103, 1'b0, 32'h0,        0, 0, 5, 1, 1, 0, 32'h0100_0004, 1, 1'b0, 2'd0}; // lw x2
      vecs[3]  = '{32'h00000063, 1'b1, 32'h0100_0040,0, 0, 4, 0, 0, 0, 32'h0100_0040, 1, 1'b0, 2'd0}; // beq taken
      vecs[4]  = '{32'h00000063, 1'b0, 32'h0100_0040,0, 0, 4, 0, 0, 0, 32'h0100_0004, 1, 1'b0, 2'd0}; // beq not taken
      vecs[5]  = '{32'h004000EF, 1'b0, 32'h0100_0042,0, 0, 3, 0, 0, 0, 32'h0100_0000, 0, 1'b1, 2'd2}; // jal misaligned
      vecs[6]  = '{32'h0000007F, 1'b0, 32'h0,        0, 0, 2, 0, 0, 0, 32'h0100_0000, 0, 1'b1, 2'd1}; // illegal
      vecs[7]  = '{32'h00000073, 1'b0, 32'h0,        0, 0, 2, 0, 0, 0, 32'h0100_0000, 0, 1'b1, 2'd3}; // ecall
      vecs[8]  = '{32'h00000013, 1'b0, 32'h0,        0, 0, 4, 0, 0, 0, 32'h0100_0004, 1, 1'b0, 2'd0}; // nop (rd=x0)
      vecs[9]  = '{32'h0000000F, 1'b0, 32'h0,        0, 0, 4, 0, 0, 0, 32'h0100_0004, 1, 1'b0, 2'd0}; // fence
      vecs[10] = '{32'h000080E7, 1'b0, 32'h0100_0100,0, 0, 4, 1, 0, 0, 32'h0100_0100, 1, 1'b0, 2'd0}; // jalr x1
      vecs[11] = '{32'h123452B7, 1'b0, 32'h0,        2, 0, 6, 1, 0, 0, 32'h0100_0004, 1, 1'b0, 2'd0}; // lui, 2 fetch waits
      vecs[12] = '{32'h00000063, 1'b0, 32'h0100_0042,0, 0, 4, 0, 0, 0, 32'h0100_0004, 1, 1'b0, 2'd0}; // untaken, odd target
      vecs[13] = '{32'h00000033, 1'b1, 32'h0100_0042,1, 0, 5, 0, 0, 0, 32'h0100_0004, 1, 1'b0, 2'd0}; // add x0, br ignored

      // reset state, sampled while reset is still high
      @(posedge clk);
      @(negedge clk);
      check("rst_state", state_o, 3'd0);
      check("rst_pc", pc_o, BASE);
      check("rst_insn", insn_o, 32'h0);
      check("rst_instret", instret_o, 32'h0);
      check("rst_trap", {trap_o, trap_cause_o}, 3'd0);
      check("rst_strobes", {imem_req_o, dmem_req_o, dmem_we_o, exec_en_o, rf_we_o}, 5'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_pc = BASE;
      m_instret = '0;
      @(negedge clk);
      check("first_fetch_req", imem_req_o, 1'b1);
      @(posedge clk);
      #1;

      foreach (vecs[k]) begin
         do_reset();
         do_insn(vecs[k].insn, vecs[k].brt, vecs[k].tgt, vecs[k].iw, vecs[k].dw, 1'b0,
                 lat_n, rfwe_n, dreq_n, dwe_n, trapped);
         check($sformatf("v%0d_lat", k), lat_n, vecs[k].exp_lat);
         check($sformatf("v%0d_rfwe", k), rfwe_n, vecs[k].exp_rfwe);
         check($sformatf("v%0d_dreq", k), dreq_n, vecs[k].exp_dreq);
         check($sformatf("v%0d_dwe", k), dwe_n, vecs[k].exp_dwe);
         check($sformatf("v%0d_pc", k), pc_o, vecs[k].exp_pc);
         check($sformatf("v%0d_instret", k), instret_o, vecs[k].exp_instret);
         check($sformatf("v%0d_trap", k), trap_o, vecs[k].exp_trap);
         check($sformatf("v%0d_cause", k), trap_cause_o, vecs[k].exp_cause);
         if (vecs[k].exp_trap) check_parked(vecs[k].exp_cause);
      end

      // PC wraps from 0xFFFF_FFFC to 0
      do_reset();
      do_insn(32'h000080E7, 1'b0, 32'hFFFF_FFFC, 0, 0, 1'b0, lat_n, rfwe_n, dreq_n, dwe_n, trapped);
      do_insn(32'h00500093, 1'b0, 32'h0, 0, 0, 1'b0, lat_n, rfwe_n, dreq_n, dwe_n, trapped);
      check("pc_wrap", pc_o, 32'h0);
      check("pc_wrap_instret", instret_o, 32'd2);

      // reset during a MEM wait, with the ack landing on the reset cycle
      do_reset();
      do_insn(32'h00500093, 1'b0, 32'h0, 0, 0, 1'b0, lat_n, rfwe_n, dreq_n, dwe_n, trapped);
      @(negedge clk);
      imem_rdata_i = 32'h0000A103;
      imem_ack_i = 1'b1;
      @(negedge clk);
      imem_ack_i = 1'b0;
      @(negedge clk);
      check("rm_exec", exec_en_o, 1'b1);
      @(negedge clk);
      check("rm_mem_req", dmem_req_o, 1'b1);
      @(negedge clk);
      check("rm_mem_state", state_o, 3'd3);
      reset = 1'b1;
      dmem_ack_i = 1'b1;
      #1;
      check("rm_req_masked", {imem_req_o, dmem_req_o, dmem_we_o, exec_en_o, rf_we_o}, 5'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      dmem_ack_i = 1'b0;
      @(negedge clk);
      check("rm_state", state_o, 3'd0);
      check("rm_pc", pc_o, BASE);
      check("rm_instret", instret_o, 32'h0);
      check("rm_insn", insn_o, 32'h0);
      check("rm_rf_we", rf_we_o, 1'b0);
      check("rm_fetch_req", imem_req_o, 1'b1);
      @(posedge clk);
      #1;
      m_pc = BASE;
      m_instret = '0;

      // randomized stream against the instruction-level model
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ri, rt;
         ri = $urandom;
         case ($urandom_range(0, 19))
            0:       ri[6:0] = 7'h73;
            1:       ri[6:0] = 7'($urandom);
            default: ri[6:0] = ops[$urandom_range(0, 9)][6:0];
         endcase
         rt = $urandom;
         if ($urandom_range(0, 9) != 0) rt[1:0] = 2'b00;
         do_insn(ri, 1'($urandom), rt, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1,
                 lat_n, rfwe_n, dreq_n, dwe_n, trapped);
         if (trapped) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
